// File: rtl/mmu_req_queue_pkg.sv
// mmu_req_queue_pkg: shared MMU request payload type and core widths
package mmu_req_queue_pkg;
  localparam int XLEN = 64;
  localparam int MMU_USER_W = 4;
  typedef struct packed {
    logic [7:0]            id;
    logic [XLEN-1:0]       addr;
    logic [XLEN-1:0]       data;
    logic [4:0]            opcode;
    logic [9:0]            funct;
    logic [MMU_USER_W-1:0] user;
  } mmu_req_t;
endpackage

// File: rtl/mmu_req_queue_if.sv
// mmu_interface: translation request bus from LSU/fetch master to the MMU
interface mmu_interface;
  import mmu_req_queue_pkg::*;
  logic [7:0]            id;
  logic [XLEN-1:0]       addr;
  logic [XLEN-1:0]       data;
  logic [4:0]            opcode;
  logic [9:0]            funct;
  logic [MMU_USER_W-1:0] user;
  logic                  valid;
  logic                  full;
  modport master (output id, addr, data, opcode, funct, user, valid, input full);
  modport slave (input id, addr, data, opcode, funct, user, valid, output full);
endinterface

// File: rtl/mmu_req_fifo_mem.sv
// mmu_req_fifo_mem: request storage, one synchronous write port and one async read port
module mmu_req_fifo_mem
  import mmu_req_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  mmu_req_t         wdata,
  input  logic [PTR_W-1:0] raddr,
  output mmu_req_t         rdata
);
  mmu_req_t mem [DEPTH];
  // storage is deliberately not reset; occupancy tracking masks stale entries
  always_ff @(posedge clk_i) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mmu_req_queue.sv
// mmu_req_queue: in-order request buffer between the MMU request bus and TLB lookup
module mmu_req_queue
  import mmu_req_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  flush_i,
  mmu_interface.slave           mmu_req,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [7:0]            req_id_o,
  output logic [XLEN-1:0]       req_addr_o,
  output logic [XLEN-1:0]       req_data_o,
  output logic [4:0]            req_opcode_o,
  output logic [9:0]            req_funct_o,
  output logic [MMU_USER_W-1:0] req_user_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic push, pop;
  mmu_req_t wdata, head, head_q;
  assign mmu_req.full = count == CNT_W'(DEPTH);
  assign req_valid_o  = count != '0;
  assign empty_o      = count == '0;
  assign count_o      = count;
  assign push = mmu_req.valid && !mmu_req.full && !flush_i;
  assign pop  = req_valid_o && req_ready_i && !flush_i;
  assign wdata = '{id: mmu_req.id, addr: mmu_req.addr, data: mmu_req.data,
                   opcode: mmu_req.opcode, funct: mmu_req.funct, user: mmu_req.user};
  mmu_req_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i (clk_i),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );
  // payload is zeroed whenever no entry is presented, so stale storage never leaks out
  assign head_q       = req_valid_o ? head : '0;
  assign req_id_o     = head_q.id;
  assign req_addr_o   = head_q.addr;
  assign req_data_o   = head_q.data;
  assign req_opcode_o = head_q.opcode;
  assign req_funct_o  = head_q.funct;
  assign req_user_o   = head_q.user;
  // pointer and occupancy tracking; flush empties the queue and drops same-cycle traffic
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push) - CNT_W'(pop);
    end
endmodule

// File: tb/tb_mmu_req_queue.sv
// tb_mmu_req_queue: directed self-checking bench for mmu_req_queue
module tb_mmu_req_queue;
  import mmu_req_queue_pkg::*;
  logic clk_i = 0, arst_i = 1, flush_i = 0, req_ready_i = 0;
  logic req_valid_o, empty_o;
  logic [7:0] req_id_o;
  logic [XLEN-1:0] req_addr_o, req_data_o;
  logic [4:0] req_opcode_o;
  logic [9:0] req_funct_o;
  logic [MMU_USER_W-1:0] req_user_o;
  logic [2:0] count_o;
  int passed = 0, total = 0;
  mmu_interface bus ();
  mmu_req_queue #(.DEPTH(4)) dut (
    .clk_i (clk_i), .arst_i (arst_i), .flush_i (flush_i), .mmu_req (bus.slave),
    .req_valid_o (req_valid_o), .req_ready_i (req_ready_i), .req_id_o (req_id_o),
    .req_addr_o (req_addr_o), .req_data_o (req_data_o), .req_opcode_o (req_opcode_o),
    .req_funct_o (req_funct_o), .req_user_o (req_user_o), .empty_o (empty_o), .count_o (count_o)
  );
  always #5 clk_i = ~clk_i;
  // structural invariants, sampled away from the active edge
  always @(negedge clk_i) begin
    assert (count_o <= 3'd4) else $error("FAIL inv_count: count_o=%0d exceeds 4", count_o);
    assert (req_valid_o === (count_o != 0)) else $error("FAIL inv_valid: valid=%b count=%0d", req_valid_o, count_o);
    assert (bus.full === (count_o == 3'd4)) else $error("FAIL inv_full: full=%b count=%0d", bus.full, count_o);
  end
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input logic v, input logic [7:0] id, input logic [XLEN-1:0] addr);
    bus.valid = v; bus.id = id; bus.addr = addr; bus.data = {56'h0, ~id};
    bus.opcode = id[4:0]; bus.funct = {2'b0, id}; bus.user = id[3:0];
  endtask
  task automatic chk_state(input string tag, input logic v, input logic [2:0] cnt, input logic fl);
    total++;
    assert (req_valid_o === v && empty_o === !v && count_o === cnt && bus.full === fl) passed++;
    else $error("FAIL %s: valid=%b empty=%b count=%0d full=%b, want valid=%b empty=%b count=%0d full=%b",
                tag, req_valid_o, empty_o, count_o, bus.full, v, !v, cnt, fl);
  endtask
  task automatic chk_head(input string tag, input logic [7:0] id);
    total++;
    assert (req_valid_o === 1'b1 && req_id_o === id && req_data_o === {56'h0, ~id} &&
            req_opcode_o === id[4:0] && req_funct_o === {2'b0, id} && req_user_o === id[3:0]) passed++;
    else $error("FAIL %s: valid=%b id=%h data=%h op=%h funct=%h user=%h, want id=%h", tag,
                req_valid_o, req_id_o, req_data_o, req_opcode_o, req_funct_o, req_user_o, id);
  endtask
  task automatic chk_zero(input string tag);
    total++;
    assert ({req_id_o, req_addr_o, req_data_o, req_opcode_o, req_funct_o, req_user_o} === '0) passed++;
    else $error("FAIL %s: payload id=%h addr=%h data=%h not zero", tag, req_id_o, req_addr_o, req_data_o);
  endtask
  initial begin
    drive(0, 8'h0, '0);
    #2;
    chk_state("reset_state", 0, 0, 0);
    chk_zero("reset_payload");
    tick;
    arst_i = 0;
    tick;
    chk_state("post_reset", 0, 0, 0);
    // single request
    req_ready_i = 1;
    drive(1, 8'h11, 64'h8000_1000);
    tick;
    drive(0, 8'h0, '0);
    chk_state("single_visible", 1, 1, 0);
    chk_head("single_head", 8'h11);
    total++;
    assert (req_addr_o === 64'h8000_1000) passed++;
    else $error("FAIL single_addr: got %h want 8000_1000", req_addr_o);
    tick;
    chk_state("single_drained", 0, 0, 0);
    chk_zero("single_zero");
    // fill to full, id 5 refused
    req_ready_i = 0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'(i), 64'(i));
      tick;
    end
    chk_state("fill_full", 1, 4, 1);
    chk_head("fill_head1", 8'h01);
    drive(1, 8'h05, 64'h5);
    tick;
    chk_state("fill_refused", 1, 4, 1);
    chk_head("fill_head1_held", 8'h01);
    req_ready_i = 1;
    tick;
    chk_state("full_pop_no_push", 1, 3, 0);
    chk_head("drain_2", 8'h02);
    tick;
    chk_state("repush_5", 1, 3, 0);
    chk_head("drain_3", 8'h03);
    drive(0, 8'h0, '0);
    tick;
    chk_head("drain_4", 8'h04);
    tick;
    chk_head("drain_5", 8'h05);
    chk_state("drain_5_cnt", 1, 1, 0);
    tick;
    chk_state("drain_empty", 0, 0, 0);
    // simultaneous push and pop at count 2
    req_ready_i = 0;
    drive(1, 8'h31, 64'h31);
    tick;
    drive(1, 8'h32, 64'h32);
    tick;
    chk_state("sim_pre", 1, 2, 0);
    chk_head("sim_head31", 8'h31);
    req_ready_i = 1;
    drive(1, 8'h33, 64'h33);
    tick;
    drive(0, 8'h0, '0);
    chk_state("sim_cnt2", 1, 2, 0);
    chk_head("sim_head32", 8'h32);
    tick;
    chk_head("sim_head33", 8'h33);
    tick;
    chk_state("sim_empty", 0, 0, 0);
    // wrap-around streaming
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(i), 64'(i));
      tick;
      chk_state("wrap_cnt", 1, 1, 0);
      chk_head("wrap_head", 8'(i));
    end
    drive(0, 8'h0, '0);
    tick;
    chk_state("wrap_empty", 0, 0, 0);
    // flush with concurrent push
    req_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'h41 + i), 64'(i));
      tick;
    end
    chk_state("flush_pre", 1, 3, 0);
    flush_i = 1;
    drive(1, 8'h22, 64'h22);
    tick;
    chk_state("flush_empty", 0, 0, 0);
    chk_zero("flush_zero");
    tick;
    chk_state("flush_held", 0, 0, 0);
    flush_i = 0;
    drive(0, 8'h0, '0);
    tick;
    chk_state("flush_no_22", 0, 0, 0);
    drive(1, 8'h51, 64'h51);
    tick;
    drive(0, 8'h0, '0);
    chk_head("post_flush_head", 8'h51);
    req_ready_i = 1;
    tick;
    chk_state("post_flush_empty", 0, 0, 0);
    // async reset between edges
    req_ready_i = 0;
    drive(1, 8'h61, 64'h61);
    tick;
    drive(1, 8'h62, 64'h62);
    tick;
    drive(0, 8'h0, '0);
    chk_state("areset_pre", 1, 2, 0);
    #2;
    arst_i = 1;
    #1;
    chk_state("areset_async", 0, 0, 0);
    chk_zero("areset_zero");
    #2;
    arst_i = 0;
    tick;
    chk_state("areset_after", 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mmu_req_queue.md
Name: mmu_req_queue

Overview:
- Slave-side request buffer on mmu_interface: accepts translation requests from the LSU/fetch master and decouples them from the TLB lookup stage.
- Stores up to DEPTH requests in order and drives `full` back to the master as flow control.
- Presents the oldest request to the TLB lookup stage over a valid/ready handshake.
- Pipeline flush discards all queued requests.

Parameters:
- DEPTH, 4, number of request entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy counter (derived, not overridden).

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- arst_i  input  1  reset; asynchronous, active-high.
- flush_i  input  1  pipeline flush; discards all entries.
- mmu_req  interface  -  mmu_interface.slave; inputs id[7:0], addr[XLEN-1:0], data[XLEN-1:0], opcode[4:0], funct[9:0], user[MMU_USER_W-1:0], valid; output full.
- req_valid_o  output  1  head entry valid toward TLB lookup.
- req_ready_i  input  1  TLB lookup accepts head entry.
- req_id_o  output  8  head id.
- req_addr_o  output  XLEN  head address.
- req_data_o  output  XLEN  head data.
- req_opcode_o  output  5  head opcode.
- req_funct_o  output  10  head funct.
- req_user_o  output  MMU_USER_W  head user field.
- empty_o  output  1  queue holds no entries.
- count_o  output  CNT_W  current occupancy.

Behaviour:
- Reset (arst_i high, async): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs during reset: full=0, req_valid_o=0, empty_o=1, count_o=0, all req_*_o payload=0.
  - Storage array is not reset.
- Push: occurs when mmu_req.valid && !full && !flush_i.
  - Writes all payload fields to entry[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: occurs when req_valid_o && req_ready_i && !flush_i.
  - rd_ptr increments modulo DEPTH.
- count update: +1 on push-only, -1 on pop-only, unchanged on simultaneous push+pop.
- full = (count == DEPTH), registered-state-derived with no combinational path from inputs.
  - A push while full is ignored, even if a pop occurs in the same cycle. The master holds valid and retries.
- req_valid_o = (count != 0). empty_o = (count == 0).
- Head payload is driven from entry[rd_ptr]; all req_*_o payload outputs are forced to 0 whenever req_valid_o=0.
- Latency: a request pushed in cycle N is visible at the output in cycle N+1 at the earliest. There is no input-to-output bypass.
- Ordering: strict FIFO; entries are never reordered or merged.
- Handshake: req_valid_o and the head payload remain stable until popped or flushed. req_ready_i may toggle freely.
- Flush (flush_i high in cycle N):
  - Next cycle: count=0, wr_ptr=rd_ptr=0, req_valid_o=0, full=0.
  - Any push or pop attempted in cycle N is discarded.
  - A flush asserted for multiple cycles holds the queue empty.
- Pointer wrap: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally. count is the sole full/empty discriminator.
- Reset mid-operation: all queued requests are lost immediately, and outputs take their reset values asynchronously.
- Assertions (bench):
  - Push never occurs while full.
  - count never exceeds DEPTH.
  - req_valid_o is never high while count==0.

Decomposition:
- XLEN and MMU_USER_W come from prv664_config.svh.
- A packed struct mmu_req_t {id, addr, data, opcode, funct, user} goes in the shared core package, so the TLB stage and this queue share one payload type.
- Natural sub-module: mmu_req_fifo_mem (DEPTH x $bits(mmu_req_t) storage with one write and one read port). Control logic (pointers, count, flush) remains in mmu_req_queue.

Test Plan:
- Single request: push id=0x11, addr=0x8000_1000 in cycle 0, req_ready_i=1 -> req_valid_o=1 in cycle 1 with id 0x11 and addr 0x8000_1000; empty_o=1 in cycle 2.
- Fill: DEPTH=4, push ids 1..5 back-to-back with req_ready_i=0 -> full=1 after the 4th push; id 5 is not accepted until a pop occurs; drain yields the order 1,2,3,4, then 5 after re-push.
- Simultaneous push+pop at count=2 -> count stays 2; the output advances to the next id; full stays 0.
- Wrap-around: perform 10 push/pop pairs with ids 0..9 -> every id pops in order; count_o never exceeds 1.
- Flush: count=3 and flush_i=1 together with a push of id 0x22 -> next cycle count_o=0, req_valid_o=0, full=0, and id 0x22 is never emitted.
- Async reset mid-stream: assert arst_i between clock edges with count=2 -> req_valid_o=0, count_o=0, payload=0 immediately, without waiting for a clock edge.
